// File: rtl/flip_game_pkg.sv
// Shared types and helpers for the falling-letter game engine.
// Holds the game state encoding, the row-width derivation and the LFSR step function.
package flip_game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } state_e;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic int unsigned calc_yw(int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LfsrTaps) : (v >> 1);
  endfunction

endpackage

// File: rtl/flip_lfsr.sv
// 16-bit Galois LFSR that can advance several steps in one clock,
// so that columns spawning together each get their own letter.
module flip_lfsr
  import flip_game_pkg::*;
#(
  parameter int unsigned MaxSteps = 1,
  parameter int unsigned StepW    = 1
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic [StepW-1:0] step,
  input  logic [15:0]      seed,
  output logic [15:0]      value
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    for (int unsigned i = 0; i < MaxSteps; i++) begin
      if (i < 32'(step)) begin
        state_d = lfsr_next(state_d);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign value = state_q;

endmodule

// File: rtl/flip_game_engine.sv
// Multi-column falling-letter game: fall divider with score-driven speed-up,
// staggered respawn, oldest-match submit resolution and IDLE/PLAY/OVER control.
module flip_game_engine
  import flip_game_pkg::*;
#(
  parameter int unsigned NUM_COLS      = 3,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ROWS          = 30,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned FALL_DIV_INIT = 25000000,
  parameter int unsigned FALL_DIV_MIN  = 2500000,
  parameter int unsigned SPEEDUP_STEP  = 1250000,
  parameter int unsigned SPEEDUP_EVERY = 4,
  parameter int unsigned RESPAWN_TICKS = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int unsigned YW           = calc_yw(ROWS)
) (
  input  logic                       clock,
  input  logic                       reset_signal,
  input  logic                       start,
  input  logic                       submit,
  input  logic [DATA_W-1:0]          user_input,
  output logic [NUM_COLS*YW-1:0]     ypos,
  output logic [NUM_COLS*DATA_W-1:0] letter,
  output logic [NUM_COLS-1:0]        active,
  output logic [SCORE_W-1:0]         score,
  output logic                       game_over,
  output logic                       playing
);

  localparam int unsigned DivW     = $clog2(FALL_DIV_INIT + 1);
  localparam int unsigned RespMax  = (NUM_COLS > RESPAWN_TICKS) ? NUM_COLS : RESPAWN_TICKS;
  localparam int unsigned RW       = $clog2(RespMax + 1);
  localparam int unsigned StepW    = $clog2(NUM_COLS + 1);
  localparam int unsigned PtsW     = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam logic [PtsW-1:0] PtsLast = PtsW'(SPEEDUP_EVERY - 1);
  localparam logic [YW-1:0]   YLast   = YW'(ROWS - 1);

  state_e                               state_q, state_d;
  logic [DivW-1:0]                      div_cnt_q, div_cnt_d;
  logic [DivW-1:0]                      reload_q, reload_d;
  logic [DivW-1:0]                      reload_nxt_q, reload_nxt_d;
  logic [SCORE_W-1:0]                   score_q, score_d;
  logic [PtsW-1:0]                      pts_q, pts_d;
  logic [NUM_COLS-1:0]                  active_q, active_d;
  logic [NUM_COLS-1:0][YW-1:0]          ypos_q, ypos_d;
  logic [NUM_COLS-1:0][DATA_W-1:0]      letter_q, letter_d;
  logic [NUM_COLS-1:0][RW-1:0]          respawn_q, respawn_d;

  logic                tick;
  logic                overflow;
  logic [NUM_COLS-1:0] win_oh;
  logic [NUM_COLS-1:0] clear;
  logic                win_found;
  logic [YW-1:0]       win_ypos;
  logic [DivW-1:0]     reload_fast;
  logic [15:0]         lfsr_value;
  logic [15:0]         lfsr_chain;
  logic [StepW-1:0]    lfsr_step;
  logic [DATA_W-1:0]   new_letter;

  flip_lfsr #(
    .MaxSteps (NUM_COLS),
    .StepW    (StepW)
  ) u_lfsr (
    .clock        (clock),
    .reset_signal (reset_signal),
    .step         (lfsr_step),
    .seed         (LFSR_SEED),
    .value        (lfsr_value)
  );

  assign tick = (state_q == StPlay) && (div_cnt_q == reload_q - DivW'(1));

  // Floor the divider without letting the subtraction wrap
  assign reload_fast = (32'(reload_nxt_q) >= FALL_DIV_MIN + SPEEDUP_STEP) ?
                       reload_nxt_q - DivW'(SPEEDUP_STEP) : DivW'(FALL_DIV_MIN);

  // Oldest matching column wins; strict compare keeps the lowest index on ties
  always_comb begin
    win_oh    = '0;
    win_found = 1'b0;
    win_ypos  = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (active_q[c] && (letter_q[c] == user_input) &&
          (!win_found || (ypos_q[c] > win_ypos))) begin
        win_oh    = '0;
        win_oh[c] = 1'b1;
        win_found = 1'b1;
        win_ypos  = ypos_q[c];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    reload_d     = reload_q;
    reload_nxt_d = reload_nxt_q;
    score_d      = score_q;
    pts_d        = pts_q;
    active_d     = active_q;
    ypos_d       = ypos_q;
    letter_d     = letter_q;
    respawn_d    = respawn_q;
    lfsr_chain   = lfsr_value;
    lfsr_step    = '0;
    overflow     = 1'b0;
    new_letter   = '0;
    clear        = submit ? win_oh : '0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d      = StPlay;
          div_cnt_d    = '0;
          reload_d     = DivW'(FALL_DIV_INIT);
          reload_nxt_d = DivW'(FALL_DIV_INIT);
          score_d      = '0;
          pts_d        = '0;
          active_d     = '0;
          ypos_d       = '0;
          letter_d     = '0;
          for (int unsigned c = 0; c < NUM_COLS; c++) begin
            respawn_d[c] = RW'(c);
          end
        end
      end

      StPlay: begin
        // A pending speed-up only takes effect at the wrap
        if (tick) begin
          div_cnt_d = '0;
          reload_d  = reload_nxt_q;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end

        if (clear != '0) begin
          active_d = active_q & ~clear;
          for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (clear[c]) begin
              respawn_d[c] = RW'(RESPAWN_TICKS);
            end
          end
          if (score_q != '1) begin
            score_d = score_q + SCORE_W'(1);
            if (pts_q == PtsLast) begin
              pts_d        = '0;
              reload_nxt_d = reload_fast;
            end else begin
              pts_d = pts_q + PtsW'(1);
            end
          end
        end

        if (tick) begin
          for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (!clear[c]) begin
              if (active_q[c]) begin
                if (ypos_q[c] == YLast) begin
                  overflow = 1'b1;
                end else begin
                  ypos_d[c] = ypos_q[c] + YW'(1);
                end
              end else if (respawn_q[c] == '0) begin
                active_d[c] = 1'b1;
                ypos_d[c]   = '0;
                lfsr_chain  = lfsr_next(lfsr_chain);
                new_letter  = lfsr_chain[DATA_W-1:0];
                letter_d[c] = (new_letter == '0) ? DATA_W'(1) : new_letter;
                lfsr_step   = lfsr_step + StepW'(1);
              end else begin
                respawn_d[c] = respawn_q[c] - RW'(1);
              end
            end
          end
        end

        if (overflow) begin
          state_d = StOver;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      reload_q     <= DivW'(FALL_DIV_INIT);
      reload_nxt_q <= DivW'(FALL_DIV_INIT);
      score_q      <= '0;
      pts_q        <= '0;
      active_q     <= '0;
      ypos_q       <= '0;
      letter_q     <= '0;
      respawn_q    <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      reload_q     <= reload_d;
      reload_nxt_q <= reload_nxt_d;
      score_q      <= score_d;
      pts_q        <= pts_d;
      active_q     <= active_d;
      ypos_q       <= ypos_d;
      letter_q     <= letter_d;
      respawn_q    <= respawn_d;
    end
  end

  assign ypos      = ypos_q;
  assign letter    = letter_q;
  assign active    = active_q;
  assign score     = score_q;
  assign game_over = (state_q == StOver);
  assign playing   = (state_q == StPlay);

endmodule

// File: tb/tb_flip_game_engine.sv
// Directed and randomized checks of flip_game_engine against a rule-level game model.
// Narrow letters are used so that letter collisions and ypos ties happen often.
module tb_flip_game_engine;

  localparam int unsigned NC   = 3;
  localparam int unsigned DW   = 2;
  localparam int unsigned ROWS = 30;
  localparam int unsigned SW   = 4;
  localparam int unsigned YW   = 5;

  logic                clock = 1'b0;
  logic                reset_signal;
  logic                start;
  logic                submit;
  logic [DW-1:0]       user_input;
  logic [NC*YW-1:0]    ypos;
  logic [NC*DW-1:0]    letter;
  logic [NC-1:0]       active;
  logic [SW-1:0]       score;
  logic                game_over;
  logic                playing;

  always #5 clock = ~clock;

  flip_game_engine #(
    .NUM_COLS      (NC),
    .DATA_W        (DW),
    .ROWS          (ROWS),
    .SCORE_W       (SW),
    .FALL_DIV_INIT (10),
    .FALL_DIV_MIN  (4),
    .SPEEDUP_STEP  (2),
    .SPEEDUP_EVERY (2),
    .RESPAWN_TICKS (2),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clock        (clock),
    .reset_signal (reset_signal),
    .start        (start),
    .submit       (submit),
    .user_input   (user_input),
    .ypos         (ypos),
    .letter       (letter),
    .active       (active),
    .score        (score),
    .game_over    (game_over),
    .playing      (playing)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Game model: 0 idle, 1 play, 2 over
  int          m_state;
  int          m_cnt, m_reload, m_reload_next, m_score;
  bit          m_act[NC];
  int          m_y[NC], m_l[NC], m_r[NC];
  logic [15:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] poly_step(input logic [15:0] s);
    logic [15:0] t;
    t = {1'b0, s[15:1]};
    if (s[0]) t = t ^ ((16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10));
    return t;
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit sub, input int uin);
    bit tick;
    int win;
    int lv;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_reload = 10; m_reload_next = 10; m_score = 0;
      m_lfsr = 16'hACE1;
      for (int c = 0; c < NC; c++) begin
        m_act[c] = 0; m_y[c] = 0; m_l[c] = 0; m_r[c] = 0;
      end
    end else if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_cnt = 0; m_reload = 10; m_reload_next = 10; m_score = 0;
        for (int c = 0; c < NC; c++) begin
          m_act[c] = 0; m_y[c] = 0; m_l[c] = 0; m_r[c] = c;
        end
      end
    end else begin
      tick = (m_cnt == m_reload - 1);
      if (tick) begin
        m_cnt = 0;
        m_reload = m_reload_next;
      end else begin
        m_cnt++;
      end
      win = -1;
      if (sub) begin
        for (int c = 0; c < NC; c++)
          if (m_act[c] && m_l[c] == uin && (win < 0 || m_y[c] > m_y[win])) win = c;
      end
      if (win >= 0) begin
        m_act[win] = 0;
        m_r[win] = 2;
        if (m_score < (1 << SW) - 1) begin
          m_score++;
          if (m_score % 2 == 0)
            m_reload_next = (m_reload_next - 2 < 4) ? 4 : m_reload_next - 2;
        end
      end
      if (tick) begin
        for (int c = 0; c < NC; c++) begin
          if (c != win) begin
            if (m_act[c]) begin
              if (m_y[c] == ROWS - 1) m_state = 2;
              else m_y[c]++;
            end else if (m_r[c] == 0) begin
              m_act[c] = 1;
              m_y[c] = 0;
              m_lfsr = poly_step(m_lfsr);
              lv = int'(m_lfsr) % (1 << DW);
              m_l[c] = (lv == 0) ? 1 : lv;
            end else begin
              m_r[c]--;
            end
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ea, ey, el;
    ea = '0; ey = '0; el = '0;
    for (int c = 0; c < NC; c++) begin
      ea[c] = m_act[c];
      ey[c*YW +: YW] = YW'(m_y[c]);
      el[c*DW +: DW] = DW'(m_l[c]);
    end
    chk("active", 32'(active), ea);
    chk("ypos", 32'(ypos), ey);
    chk("letter", 32'(letter), el);
    chk("score", 32'(score), 32'(m_score));
    chk("playing", 32'(playing), 32'(m_state == 1));
    chk("game_over", 32'(game_over), 32'(m_state == 2));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step(reset_signal, start, submit, int'(user_input));
    #1;
    check_outputs();
  endtask

  task automatic wait_y0_change(output int n, output bit ok);
    logic [YW-1:0] y0;
    y0 = ypos[YW-1:0];
    ok = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n++;
      if (ypos[YW-1:0] != y0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic drive_score(input int target, output bit ok);
    int best;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_score >= target) begin
        ok = 1;
        break;
      end
      best = -1;
      for (int c = 0; c < NC; c++)
        if (m_act[c] && (best < 0 || m_y[c] > m_y[best])) best = c;
      if (best >= 0 && i % 3 == 0) begin
        submit = 1;
        user_input = DW'(m_l[best]);
      end
      cyc();
      submit = 0;
    end
  endtask

  int  first, n, ticks;
  bit  ok;
  int  targets[4] = '{2, 4, 6, 8};
  int  spacing[4] = '{8, 6, 4, 4};
  logic [YW-1:0] y1;

  initial begin
    reset_signal = 1; start = 0; submit = 0; user_input = '0;
    repeat (3) cyc();
    reset_signal = 0;
    cyc();
    chk("reset_active", 32'(active), 0);
    chk("reset_score", 32'(score), 0);

    // Start and staggered spawns
    start = 1; cyc(); start = 0;
    chk("start_playing", 32'(playing), 1);
    first = 0;
    for (int i = 1; i <= 40 && active == '0; i++) begin cyc(); first = i; end
    chk("first_tick_latency", first, 10);
    chk("first_tick_active", 32'(active), 32'b001);
    chk("first_tick_ypos0", 32'(ypos[YW-1:0]), 0);
    first = 0;
    for (int i = 1; i <= 40 && active == 3'b001; i++) begin cyc(); first = i; end
    chk("second_tick_spacing", first, 10);
    chk("second_tick_active", 32'(active), 32'b011);
    first = 0;
    for (int i = 1; i <= 40 && active == 3'b011; i++) begin cyc(); first = i; end
    chk("third_tick_spacing", first, 10);
    chk("third_tick_active", 32'(active), 32'b111);

    // Clear column 0 and watch its delayed respawn
    submit = 1; user_input = DW'(m_l[0]); cyc(); submit = 0;
    chk("clear_col0", 32'(active[0]), 0);
    chk("clear_score", 32'(score), 1);
    ticks = 0;
    for (int i = 0; i < 100 && !active[0]; i++) begin
      y1 = ypos[2*YW-1:YW];
      cyc();
      if (ypos[2*YW-1:YW] != y1) ticks++;
    end
    chk("respawn_ticks", ticks, 3);
    chk("respawn_ypos0", 32'(ypos[YW-1:0]), 0);
    chk("respawn_letter_nonzero", 32'(letter[DW-1:0] != '0), 1);

    // Score-driven speed-up down to the floor
    for (int k = 0; k < 4; k++) begin
      drive_score(targets[k], ok);
      chk("reach_score", 32'(ok), 1);
      for (int i = 0; i < 200 && active != 3'b111; i++) cyc();
      wait_y0_change(n, ok);
      wait_y0_change(n, ok);
      chk("speedup_wait", 32'(ok), 1);
      chk("tick_spacing", n, spacing[k]);
    end

    // Overflow, frozen display, restart
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (game_over) begin ok = 1; break; end
    end
    chk("reach_game_over", 32'(ok), 1);
    for (int i = 0; i < 50; i++) begin
      submit = 1'($urandom_range(0, 1));
      user_input = DW'($urandom_range(0, 3));
      cyc();
    end
    submit = 0;
    chk("over_still", 32'(game_over), 1);
    start = 1; cyc(); start = 0;
    chk("restart_playing", 32'(playing), 1);
    chk("restart_score", 32'(score), 0);

    // Clear column 0 at the last row on the very tick that would end the game
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_state == 1 && m_act[0] && m_y[0] == ROWS - 1 && m_cnt == m_reload - 1) begin
        ok = 1;
        break;
      end
      cyc();
    end
    chk("reach_last_row", 32'(ok), 1);
    submit = 1; user_input = DW'(m_l[0]); cyc(); submit = 0;
    chk("edge_no_over", 32'(game_over), 0);
    chk("edge_cleared", 32'(active[0]), 0);
    chk("edge_score", 32'(score), 1);
    repeat (5) cyc();

    // Reset beats start mid-game
    reset_signal = 1; start = 1; cyc(); reset_signal = 0; start = 0;
    chk("reset_mid_playing", 32'(playing), 0);
    chk("reset_mid_active", 32'(active), 0);
    chk("reset_mid_score", 32'(score), 0);
    cyc();

    // Randomized play against the model
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 999);
      reset_signal = (n == 0);
      start = (n > 0 && n < 4);
      submit = ($urandom_range(0, 2) == 0);
      user_input = DW'($urandom_range(0, 3));
      cyc();
    end
    reset_signal = 0; start = 0; submit = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
